// File: rtl/freq_div_gen.sv
// Programmable divide-by-(T+1) clock-enable generator.
// Emits a one-cycle tick and a 50%-duty divided clock; all outputs registered.
module freq_div_gen #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   DEF_DIV = WIDTH'(3)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] div_cur,
  output logic             tick,
  output logic             clk_out,
  output logic             pend
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic             pend_q, pend_d;
  logic             term;
  logic             idle_ld;
  logic             run_term;
  logic             run_step;

  // cnt > div_cur is unreachable normally; wrapping on it self-recovers.
  assign term = (cnt_q >= div_cur_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign idle_ld  = (state_d == IDLE) && load;
  assign run_term = (state_d == RUN) && term;
  assign run_step = (state_d == RUN) && !term;

  always_comb begin
    cnt_d     = cnt_q;
    div_cur_d = div_cur_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;
    unique case (1'b1)
      idle_ld: begin
        div_cur_d = div_val;
        cnt_d     = '0;
        pend_d    = 1'b0;
      end
      run_term: begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_out_d = ~clk_out_q;
        pend_d    = 1'b0;
        if (load)        div_cur_d = div_val;
        else if (pend_q) div_cur_d = shadow_q;
      end
      run_step: begin
        cnt_d = cnt_q + WIDTH'(1);
        if (load) begin
          shadow_d = div_val;
          pend_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_cur_q <= DEF_DIV;
      shadow_q  <= '0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      shadow_q  <= shadow_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      pend_q    <= pend_d;
    end
  end

  assign cnt     = cnt_q;
  assign div_cur = div_cur_q;
  assign tick    = tick_q;
  assign clk_out = clk_out_q;
  assign pend    = pend_q;

endmodule

// File: tb/tb_freq_div_gen.sv
// Directed bench for freq_div_gen.
// Inputs change 1ns after each rising edge; outputs sampled there too.
module tb_freq_div_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] div_val;
  logic [3:0] cnt;
  logic [3:0] div_cur;
  logic       tick;
  logic       clk_out;
  logic       pend;

  int checks = 0;
  int errors = 0;

  freq_div_gen #(.WIDTH(4), .DEF_DIV(4'd3)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .div_val (div_val),
    .cnt     (cnt),
    .div_cur (div_cur),
    .tick    (tick),
    .clk_out (clk_out),
    .pend    (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_load(input logic [3:0] v);
    en      = 1'b0;
    load    = 1'b1;
    div_val = v;
    step();
    load    = 1'b0;
  endtask

  task automatic pulse_reset();
    rst  = 1'b0;
    en   = 1'b0;
    load = 1'b0;
    step();
    rst  = 1'b1;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    en      = 1'b1;
    load    = 1'b0;
    div_val = 4'd0;
    repeat (5) step();
    checks++;
    if ({cnt, div_cur, tick, clk_out, pend} !== {4'd0, 4'd3, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d div=%0d tick=%b clk=%b pend=%b want 0 3 0 0 0",
               cnt, div_cur, tick, clk_out, pend);
    end
    rst = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      logic [3:0] ec;
      logic       et, eo;
      step();
      ec = 4'(c % 4);
      et = (c % 4 == 0);
      eo = ((c >= 4) && (c < 8)) || ((c >= 12) && (c < 16));
      checks++;
      if ({cnt, tick, clk_out} !== {ec, et, eo}) begin
        errors++;
        $display("FAIL reset_run c=%0d: cnt=%0d tick=%b clk=%b want %0d %b %b",
                 c, cnt, tick, clk_out, ec, et, eo);
      end
    end
  endtask

  task automatic test_divide_values();
    idle_load(4'd0);
    checks++;
    if ({div_cur, cnt, pend} !== {4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL div0_load: div=%0d cnt=%0d pend=%b want 0 0 0",
               div_cur, cnt, pend);
    end
    en = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      logic eo;
      step();
      eo = (c % 2 == 1);
      checks++;
      if ({cnt, tick, clk_out} !== {4'd0, 1'b1, eo}) begin
        errors++;
        $display("FAIL div0_run c=%0d: cnt=%0d tick=%b clk=%b want 0 1 %b",
                 c, cnt, tick, clk_out, eo);
      end
    end
    idle_load(4'd15);
    en = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      logic [3:0] ec;
      logic       et, eo;
      step();
      ec = 4'(c % 16);
      et = (c % 16 == 0);
      eo = (c >= 16) && (c < 32);
      checks++;
      if ({cnt, tick, clk_out} !== {ec, et, eo}) begin
        errors++;
        $display("FAIL div15_run c=%0d: cnt=%0d tick=%b clk=%b want %0d %b %b",
                 c, cnt, tick, clk_out, ec, et, eo);
      end
    end
  endtask

  task automatic test_deferred_load();
    idle_load(4'd5);
    en = 1'b1;
    step();
    load    = 1'b1;
    div_val = 4'd4;
    step();
    div_val = 4'd2;
    step();
    load = 1'b0;
    checks++;
    if ({cnt, div_cur, pend} !== {4'd3, 4'd5, 1'b1}) begin
      errors++;
      $display("FAIL defer_pending: cnt=%0d div=%0d pend=%b want 3 5 1",
               cnt, div_cur, pend);
    end
    step();
    step();
    checks++;
    if ({cnt, pend, tick} !== {4'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL defer_hold: cnt=%0d pend=%b tick=%b want 5 1 0",
               cnt, pend, tick);
    end
    step();
    checks++;
    if ({cnt, tick, div_cur, pend} !== {4'd0, 1'b1, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL defer_wrap: cnt=%0d tick=%b div=%0d pend=%b want 0 1 2 0",
               cnt, tick, div_cur, pend);
    end
    for (int c = 1; c <= 6; c++) begin
      logic et;
      step();
      et = (c % 3 == 0);
      checks++;
      if (tick !== et) begin
        errors++;
        $display("FAIL defer_period c=%0d: tick=%b want %b", c, tick, et);
      end
    end
  endtask

  task automatic test_load_terminal();
    idle_load(4'd3);
    en = 1'b1;
    repeat (3) step();
    checks++;
    if (cnt !== 4'd3) begin
      errors++;
      $display("FAIL term_pre: cnt=%0d want 3", cnt);
    end
    load    = 1'b1;
    div_val = 4'd6;
    step();
    load = 1'b0;
    checks++;
    if ({cnt, tick, div_cur, pend} !== {4'd0, 1'b1, 4'd6, 1'b0}) begin
      errors++;
      $display("FAIL term_load: cnt=%0d tick=%b div=%0d pend=%b want 0 1 6 0",
               cnt, tick, div_cur, pend);
    end
    for (int c = 1; c <= 7; c++) begin
      logic [3:0] ec;
      logic       et;
      step();
      ec = 4'(c % 7);
      et = (c == 7);
      checks++;
      if ({cnt, tick} !== {ec, et}) begin
        errors++;
        $display("FAIL term_period c=%0d: cnt=%0d tick=%b want %0d %b",
                 c, cnt, tick, ec, et);
      end
    end
  endtask

  task automatic test_enable_pause();
    pulse_reset();
    idle_load(4'd7);
    en = 1'b1;
    repeat (4) step();
    en = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++;
      if ({cnt, tick, clk_out} !== {4'd4, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL pause_hold c=%0d: cnt=%0d tick=%b clk=%b want 4 0 0",
                 c, cnt, tick, clk_out);
      end
    end
    en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      logic [3:0] ec;
      logic       et;
      step();
      ec = (c == 4) ? 4'd0 : 4'(4 + c);
      et = (c == 4);
      checks++;
      if ({cnt, tick, clk_out} !== {ec, et, et}) begin
        errors++;
        $display("FAIL pause_resume c=%0d: cnt=%0d tick=%b clk=%b want %0d %b %b",
                 c, cnt, tick, clk_out, ec, et, et);
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    idle_load(4'd9);
    en = 1'b1;
    repeat (5) step();
    load    = 1'b1;
    div_val = 4'd2;
    step();
    load = 1'b0;
    checks++;
    if ({cnt, pend, div_cur} !== {4'd6, 1'b1, 4'd9}) begin
      errors++;
      $display("FAIL arst_pre: cnt=%0d pend=%b div=%0d want 6 1 9",
               cnt, pend, div_cur);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({cnt, div_cur, tick, clk_out, pend} !== {4'd0, 4'd3, 3'b000}) begin
      errors++;
      $display("FAIL arst_clear: cnt=%0d div=%0d tick=%b clk=%b pend=%b want 0 3 0 0 0",
               cnt, div_cur, tick, clk_out, pend);
    end
    #1;
    rst = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      logic [3:0] ec;
      logic       et;
      step();
      ec = 4'(c % 4);
      et = (c % 4 == 0);
      checks++;
      if ({cnt, tick, pend, div_cur} !== {ec, et, 1'b0, 4'd3}) begin
        errors++;
        $display("FAIL arst_restart c=%0d: cnt=%0d tick=%b pend=%b div=%0d want %0d %b 0 3",
                 c, cnt, tick, pend, div_cur, ec, et);
      end
    end
  endtask

  initial begin
    rst     = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    div_val = 4'd0;
    test_reset();
    test_divide_values();
    test_deferred_load();
    test_load_terminal();
    test_enable_pause();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
